// File: rtl/single_exp_split_arbiter_pkg.sv
// Single-precision field layout, split result record and leading-zero helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package single_fp_pkg;

  localparam int EXP_BIAS  = 127;
  localparam int EXP_MAX   = 255;
  localparam int FRAC_W    = 23;
  localparam int EXP_OUT_W = 9;

  // Two's-complement encodings of the fixed output exponents.
  localparam logic [EXP_OUT_W-1:0] EXP_OUT_INF    = 9'd128;
  localparam logic [EXP_OUT_W-1:0] EXP_OUT_SUBNRM = 9'h181;  // -127

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [FRAC_W-1:0] frac;
  } single_t;

  typedef struct packed {
    logic [31:0]          mant;
    logic [EXP_OUT_W-1:0] exp;
    logic                 zero;
    logic                 inf_nan;
  } split_t;

  // Leading zeros of a non-zero fraction (0..22); an all-zero input returns 23.
  function automatic logic [4:0] clz_frac(input logic [FRAC_W-1:0] f);
    logic [4:0] n;
    logic       found;
    n     = '0;
    found = 1'b0;
    for (int i = FRAC_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (f[i]) begin
          found = 1'b1;
        end else begin
          n = n + 5'd1;
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/single_exp_split_arbiter_if.sv
// Request/result bundle between the requesters, the arbiter and the consumer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the request side and the result side.
interface single_exp_split_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_mant;
  logic [8:0]            out_exp;
  logic [ID_W-1:0]       out_id;
  logic                  out_zero;
  logic                  out_inf_nan;

  // Requesters plus the result consumer.
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_mant, out_exp, out_id, out_zero, out_inf_nan
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_mant, out_exp, out_id, out_zero, out_inf_nan
  );

endinterface

// File: rtl/single_exp_split_arbiter_split.sv
// Splits one IEEE-754 single into {sign,127,frac} mantissa, unbiased exponent and class flags.
// Latency: combinational; subnormal normalization (SINGLE_SUBNORMAL_NORM_EN) stays in the same cycle.
// Backpressure: none, pure function of the operand.
module single_exp_split
  import single_fp_pkg::*;
(
  input  logic [31:0] operand,
  output split_t      result
);

  single_t op;
  assign op = single_t'(operand);

`ifdef SINGLE_SUBNORMAL_NORM_EN
  logic [4:0]        lz;
  logic [FRAC_W-1:0] frac_norm;
  assign lz        = clz_frac(op.frac);
  // Shifting past the leading one drops the hidden bit, leaving the new fraction.
  assign frac_norm = op.frac << (lz + 5'd1);
`endif

  // Classify the operand and build the rebased mantissa and exponent.
  always_comb begin
    result         = '0;
    result.mant    = {op.sign, 8'(EXP_BIAS), op.frac};
    if (op.exp == 8'(EXP_MAX)) begin
      result.exp     = EXP_OUT_INF;
      result.inf_nan = 1'b1;
    end else if (op.exp != 8'd0) begin
      result.exp = {1'b0, op.exp} - 9'(EXP_BIAS);
    end else if (op.frac == '0) begin
      result.exp  = '0;
      result.zero = 1'b1;
    end else begin
`ifdef SINGLE_SUBNORMAL_NORM_EN
      result.mant = {op.sign, 8'(EXP_BIAS), frac_norm};
      result.exp  = EXP_OUT_SUBNRM - {4'd0, lz};
`else
      result.exp  = EXP_OUT_SUBNRM;
`endif
    end
  end

endmodule

// File: rtl/single_exp_split_arbiter.sv
// Round-robin shares one single-precision exponent/mantissa split unit among NUM_REQ requesters.
// Latency: 1 cycle from request transfer to registered result; 1 result/cycle when out_ready=1.
// Backpressure: result held and all req_ready low while out_valid & !out_ready. Option: SINGLE_SUBNORMAL_NORM_EN.
module single_exp_split_arbiter
  import single_fp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  single_exp_split_arbiter_if.slave     bus
);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic               accept;
  logic               xfer;
  logic [31:0]        operand;
  split_t             split_res;

  logic               out_valid_q;
  split_t             result_q;
  logic [ID_W-1:0]    id_q;

  // Output register can take a new result when empty or retiring this cycle.
  assign accept = !out_valid_q || bus.out_ready;

  // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      if (!found && bus.req_valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        win      = ID_W'(j);
      end
    end
  end

  assign bus.req_ready = (rst_n && accept) ? grant : '0;
  assign xfer          = rst_n && accept && found;
  assign operand       = bus.req_data[{win, 5'd0} +: 32];
  assign ptr_next      = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  single_exp_split u_split (
    .operand (operand),
    .result  (split_res)
  );

  // Output register and round-robin pointer; both move only when accepting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      id_q        <= '0;
      ptr         <= '0;
    end else if (accept) begin
      out_valid_q <= xfer;
      if (xfer) begin
        result_q <= split_res;
        id_q     <= win;
        ptr      <= ptr_next;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_mant    = result_q.mant;
  assign bus.out_exp     = result_q.exp;
  assign bus.out_id      = id_q;
  assign bus.out_zero    = result_q.zero;
  assign bus.out_inf_nan = result_q.inf_nan;

endmodule

// File: tb/tb_single_exp_split_arbiter.sv
// Directed bench for the round-robin exponent/mantissa split arbiter.
// Latency: expects results one edge after each transfer.
// Backpressure: exercises out_ready stalls and reset during a held result.
module tb_single_exp_split_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  single_exp_split_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  single_exp_split_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          req;
    logic [31:0] op;
    logic [31:0] mant;
    int          ex;
    logic        zero;
    logic        inf;
  } vec_t;

  vec_t vt [11];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk_exp(input string name, input int req);
    logic [8:0] e;
    e = 9'(req);
    chk(name, {23'd0, bus.out_exp}, {23'd0, e});
  endtask

  task automatic drive_one(input int r, input logic [31:0] op);
    bus.req_data          = '0;
    bus.req_data[32*r +: 32] = op;
    bus.req_valid         = '0;
    bus.req_valid[r]      = 1'b1;
  endtask

  initial begin
    logic [3:0] rdy;
    checks = 0;
    errors = 0;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;

    vt[0]  = '{0, 32'h40490FDB, 32'h3FC90FDB,    1, 1'b0, 1'b0};
    vt[1]  = '{2, 32'hC1200000, 32'hBFA00000,    3, 1'b0, 1'b0};
    vt[2]  = '{1, 32'h7F800000, 32'h3F800000,  128, 1'b0, 1'b1};
    vt[3]  = '{3, 32'h80000000, 32'hBF800000,    0, 1'b1, 1'b0};
    vt[4]  = '{1, 32'h3F800000, 32'h3F800000,    0, 1'b0, 1'b0};
    vt[5]  = '{2, 32'h00800000, 32'h3F800000, -126, 1'b0, 1'b0};
    vt[6]  = '{3, 32'h7F7FFFFF, 32'h3FFFFFFF,  127, 1'b0, 1'b0};
    vt[7]  = '{0, 32'h7FC00000, 32'h3FC00000,  128, 1'b0, 1'b1};
`ifdef SINGLE_SUBNORMAL_NORM_EN
    vt[8]  = '{0, 32'h00000001, 32'h3F800000, -149, 1'b0, 1'b0};
    vt[9]  = '{1, 32'h80400000, 32'hBF800000, -127, 1'b0, 1'b0};
    vt[10] = '{2, 32'h00000003, 32'h3FC00000, -148, 1'b0, 1'b0};
`else
    vt[8]  = '{0, 32'h00000001, 32'h3F800001, -127, 1'b0, 1'b0};
    vt[9]  = '{1, 32'h80400000, 32'hBFC00000, -127, 1'b0, 1'b0};
    vt[10] = '{2, 32'h00000003, 32'h3F800003, -127, 1'b0, 1'b0};
`endif

    // Reset state, with every requester asking during reset.
    @(negedge clk);
    bus.req_valid = '1;
    #1;
    chk("rst_valid",  {31'd0, bus.out_valid},   32'd0);
    chk("rst_mant",   bus.out_mant,             32'd0);
    chk_exp("rst_exp", 0);
    chk("rst_id",     {30'd0, bus.out_id},      32'd0);
    chk("rst_zero",   {31'd0, bus.out_zero},    32'd0);
    chk("rst_inf",    {31'd0, bus.out_inf_nan}, 32'd0);
    chk("rst_ready",  {28'd0, bus.req_ready},   32'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single-requester vectors with a bubble between them.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive_one(vt[i].req, vt[i].op);
      rdy = 4'b0001 << vt[i].req;
      #1;
      chk("vec_ready", {28'd0, bus.req_ready}, {28'd0, rdy});
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      chk("vec_valid", {31'd0, bus.out_valid},   32'd1);
      chk("vec_mant",  bus.out_mant,             vt[i].mant);
      chk_exp("vec_exp", vt[i].ex);
      chk("vec_id",    {30'd0, bus.out_id},      32'(vt[i].req));
      chk("vec_zero",  {31'd0, bus.out_zero},    {31'd0, vt[i].zero});
      chk("vec_inf",   {31'd0, bus.out_inf_nan}, {31'd0, vt[i].inf});
    end

    // Round-robin fairness from a freshly reset pointer, back-to-back.
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    for (int r = 0; r < NUM_REQ; r++) bus.req_data[32*r +: 32] = 32'h3F800000 + 32'(r);
    bus.req_valid = '1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      rdy = 4'b0001 << (i % 4);
      chk("rr_ready", {28'd0, bus.req_ready}, {28'd0, rdy});
      if (i > 0) begin
        chk("rr_id",    {30'd0, bus.out_id},    32'((i - 1) % 4));
        chk("rr_valid", {31'd0, bus.out_valid}, 32'd1);
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    #1;
    chk("rr_last_id",   {30'd0, bus.out_id}, 32'd3);
    chk("rr_last_mant", bus.out_mant,        32'h3F800003);

    // Stall: result from requester 2 held while out_ready is low.
    @(negedge clk);
    drive_one(2, 32'hC1200000);
    bus.out_ready = 1'b1;
    #1;
    chk("stall_load_ready", {28'd0, bus.req_ready}, 32'h4);
    @(negedge clk);
    drive_one(0, 32'h3F800000);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_mant",  bus.out_mant,           32'hBFA00000);
      chk_exp("stall_exp", 3);
      chk("stall_id",    {30'd0, bus.out_id},    32'd2);
      chk("stall_ready", {28'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_ready", {28'd0, bus.req_ready}, 32'h1);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk("unstall_id",   {30'd0, bus.out_id}, 32'd0);
    chk("unstall_mant", bus.out_mant,        32'h3F800000);

    // Reset while a result is held, then requesters 1 and 3 together.
    @(negedge clk);
    drive_one(1, 32'h7F800000);
    bus.out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_valid", {31'd0, bus.out_valid},   32'd1);
    chk("pre_rst_inf",   {31'd0, bus.out_inf_nan}, 32'd1);
    bus.req_data[32*3 +: 32] = 32'h80000000;
    bus.req_valid = 4'b1010;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_ready", {28'd0, bus.req_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready1", {28'd0, bus.req_ready}, 32'h2);
    @(negedge clk);
    bus.req_valid = 4'b1000;
    #1;
    chk("post_rst_id1",    {30'd0, bus.out_id},    32'd1);
    chk("post_rst_ready3", {28'd0, bus.req_ready}, 32'h8);
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    chk("post_rst_id3",   {30'd0, bus.out_id},   32'd3);
    chk("post_rst_zero",  {31'd0, bus.out_zero}, 32'd1);
    chk("post_rst_mant",  bus.out_mant,          32'hBF800000);
    @(negedge clk);
    #1;
    chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/single_exp_split_arbiter.md
Name: single_exp_split_arbiter

Overview:
- Shares one single-precision exponent/mantissa split unit among NUM_REQ requesters.
- Each request carries an IEEE-754 single. The block returns:
  - the mantissa rebased to biased exponent 127, so its value is in [1,2) with the sign kept;
  - the unbiased exponent;
  - the requester id and class flags.
- It sits in front of single-precision log2/sqrt/reciprocal units, which need the 1.m × 2^e decomposition.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester id.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester valid.
- req_ready  output  NUM_REQ  per-requester ready; a transfer occurs when valid & ready.
- req_data  input  NUM_REQ*32  flat operands; requester i occupies [32*i+31:32*i].
- out_valid  output  1  result valid.
- out_ready  input  1  downstream ready.
- out_mant  output  32  {sign, 8'd127, fraction}.
- out_exp  output  9  signed unbiased exponent.
- out_id  output  ID_W  index of the requester that was served.
- out_zero  output  1  operand was ±0.
- out_inf_nan  output  1  operand exponent field was 255.

Behaviour:
- Reset (asynchronous, active-low): out_valid=0, out_mant=0, out_exp=0, out_id=0, flags=0, round-robin pointer=0. req_ready is 0 while rst_n is low.
- accept = !out_valid | out_ready.
- Arbitration is round-robin:
  - The search starts at the pointer and wraps modulo NUM_REQ.
  - The first asserted req_valid wins and is granted only when accept=1.
  - req_ready[i] = accept & grant[i]. At most one req_ready is high in any cycle.
  - req_ready is combinational from req_valid, out_valid and out_ready.
- The pointer moves to (winner+1) mod NUM_REQ only on a transfer. It is unchanged on idle cycles and stall cycles.
- Latency is 1 cycle. The transfer at edge N loads the output register, so the result is visible after edge N.
- Throughput is 1 result per cycle while out_ready=1.
- Stall: while out_valid & !out_ready, all outputs hold and every req_ready is 0.
- Simultaneous out_ready and a new request: the old result retires and the new result loads on the same edge, with no bubble.
- Split rules. E = bits[30:23], F = bits[22:0], s = bit 31:
  - Normal (E in 1..254): out_mant = {s, 127, F}, out_exp = E - 127.
  - E=255: out_mant = {s, 127, F}, out_exp = 128, out_inf_nan = 1.
  - Zero (E=0, F=0): out_mant = {s, 127, 0}, out_exp = 0, out_zero = 1.
  - Subnormal (E=0, F≠0): handling is defined under Optional Feature.
- No requester is ever starved: with all NUM_REQ requesters continuously valid and out_ready=1, each is granted exactly once per NUM_REQ transfers.
- Reset asserted mid-operation clears the pending result immediately. No transfer happens during reset.

Optional Feature:
- Macro: SINGLE_SUBNORMAL_NORM_EN.
- Defined: a subnormal is normalized.
  - lz = number of leading zeros of F (0..22).
  - F' = (F << (lz+1)) truncated to 23 bits.
  - out_mant = {s, 127, F'}, out_exp = -127 - lz.
  - Normalization stays within the same single cycle.
- Not defined: a subnormal is passed through as out_mant = {s, 127, F}, out_exp = -127.
- In both modes, subnormals set no flag.

Decomposition:
- Package single_fp_pkg holds:
  - EXP_BIAS=127, EXP_MAX=255, FRAC_W=23, EXP_OUT_W=9;
  - typedef single_t, a packed struct {sign, exp[7:0], frac[22:0]};
  - typedef split_t, a packed struct {mant, exp, zero, inf_nan}.
- One sub-module, single_exp_split: purely combinational; it takes a 32-bit operand and returns split_t, including the macro-controlled normalization.
- The arbiter, pointer and output register stay in the top module.

Test Plan:
- Requester 0 sends 0x40490FDB with out_ready=1 → one cycle later out_valid=1, out_mant=0x3FC90FDB, out_exp=1, out_id=0, flags=0.
- NUM_REQ=4, all req_valid=1 for 8 transfers, out_ready=1 → out_id sequence 0,1,2,3,0,1,2,3; one result per cycle.
- Requester 2 sends 0xC1200000 while out_ready=0 for 3 cycles → out_mant=0xBFA00000 and out_exp=3 stay stable; all req_ready=0; the next request is accepted on the cycle out_ready rises.
- Operands 0x7F800000, then 0x80000000 → first out_exp=128, out_inf_nan=1, out_mant=0x3F800000; second out_zero=1, out_exp=0, out_mant=0xBF800000.
- Operand 0x00000001 → without the macro out_exp=-127, out_mant=0x3F800001; with SINGLE_SUBNORMAL_NORM_EN out_exp=-149, out_mant=0x3F800000.
- rst_n pulsed low while out_valid=1 and out_ready=0 → out_valid=0 immediately and pointer=0; after release, simultaneous requests from 1 and 3 are served in the order 1 then 3.
